// File: rtl/sft_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sft_pkg
// Purpose  : Shared types and constants for the shift-register controller.
//            Holds the controller state encoding, the LR_sft_en control codes
//            and the default data / count widths.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package sft_pkg;

  // Default widths; the count field must be able to express DATA_W itself.
  localparam int DATA_W_DEF = 9;
  localparam int CNT_W_DEF  = 4;

  // Controller states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Shift-control codes driven onto LR_sft_en.
  localparam logic [1:0] SFT_NONE  = 2'b00;
  localparam logic [1:0] SFT_LEFT  = 2'b10;
  localparam logic [1:0] SFT_RIGHT = 2'b11;

  // Map the captured direction bit onto a shift-control code.
  function automatic logic [1:0] sft_code(input logic dir);
    return dir ? SFT_RIGHT : SFT_LEFT;
  endfunction

endpackage : sft_pkg
`default_nettype wire

// File: rtl/sft_register.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sft_register
// Purpose  : DATA_W-bit load/shift register driven by sft_reg_ctrl.
//            Shift has priority over load; shifts insert zeros.
// Ports    : sys_clk     - clock, rising edge
//            rst         - synchronous active-high reset, clears contents
//            ld_sft_reg  - load strobe
//            sft_reg_in  - parallel load data
//            LR_sft_en   - 2'b10 shift left, 2'b11 shift right, else hold
//            sft_reg_out - register contents
// Revision : 1.0 - initial release
// ============================================================================
module sft_register
  import sft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              ld_sft_reg,
  input  logic [DATA_W-1:0] sft_reg_in,
  input  logic [1:0]        LR_sft_en,
  output logic [DATA_W-1:0] sft_reg_out
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (LR_sft_en == SFT_LEFT) begin
      data_q <= {data_q[DATA_W-2:0], 1'b0};
    end else if (LR_sft_en == SFT_RIGHT) begin
      data_q <= {1'b0, data_q[DATA_W-1:1]};
    end else if (ld_sft_reg) begin
      data_q <= sft_reg_in;
    end
  end

  assign sft_reg_out = data_q;

endmodule : sft_register
`default_nettype wire

// File: rtl/sft_reg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sft_reg_ctrl
// Purpose  : Command FSM in front of sft_register. Accepts one command
//            (load word, direction, shift count) per handshake, issues one
//            load cycle followed by up to DATA_W shift cycles, then pulses
//            done. Load and shift are never asserted in the same cycle.
// Ports    : sys_clk    - clock, rising edge
//            rst        - synchronous active-high reset
//            cmd_req    - command valid (ignored unless cmd_rdy)
//            cmd_rdy    - controller idle, command will be accepted
//            cmd_data   - word to load
//            cmd_dir    - 0 shift left, 1 shift right
//            cmd_cnt    - number of shifts, saturates at DATA_W
//            ld_sft_reg - load strobe to the register
//            sft_reg_in - captured load word
//            LR_sft_en  - shift control to the register
//            busy       - high in LOAD, SHIFT, DONE
//            done       - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module sft_reg_ctrl
  import sft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF    // 2**CNT_W must exceed DATA_W
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              cmd_req,
  output logic              cmd_rdy,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_dir,
  input  logic [CNT_W-1:0]  cmd_cnt,
  output logic              ld_sft_reg,
  output logic [DATA_W-1:0] sft_reg_in,
  output logic [1:0]        LR_sft_en,
  output logic              busy,
  output logic              done
);

  // More shifts than the register width would only keep inserting zeros.
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              dir_q,   dir_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Output flops; their next values are decoded from the next state so the
  // pins line up with state_q without any input-to-output path.
  logic              ld_q,    ld_d;
  logic [1:0]        lr_q,    lr_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              rdy_q,   rdy_d;

  // --------------------------------------------------------------------------
  // Next-state and captured-field logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    data_d  = data_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_req) begin
          data_d  = cmd_data;
          dir_d   = cmd_dir;
          cnt_d   = (cmd_cnt > CNT_SAT) ? CNT_SAT : cmd_cnt;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = (cnt_q != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        cnt_d = cnt_q - CNT_ONE;
        // cnt_q is never 0 here; <= keeps a corrupted counter from looping.
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Moore output decode of the next state
  // --------------------------------------------------------------------------
  always_comb begin
    ld_d   = (state_d == ST_LOAD);
    lr_d   = (state_d == ST_SHIFT) ? sft_code(dir_d) : SFT_NONE;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    rdy_d  = (state_d == ST_IDLE);
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
      ld_q    <= 1'b0;
      lr_q    <= SFT_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      ld_q    <= ld_d;
      lr_q    <= lr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign cmd_rdy    = rdy_q;
  assign ld_sft_reg = ld_q;
  assign sft_reg_in = data_q;
  assign LR_sft_en  = lr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule : sft_reg_ctrl
`default_nettype wire

// File: tb/tb_sft_reg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sft_reg_ctrl
// Purpose  : Self-checking bench for sft_reg_ctrl driving sft_register.
//            Directed cases plus randomized commands, checked cycle by cycle
//            against an expected command timeline and an arithmetic model of
//            the final register value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sft_reg_ctrl;

  localparam int DATA_W = 9;
  localparam int CNT_W  = 4;

  logic              sys_clk = 1'b0;
  logic              rst     = 1'b1;
  logic              reg_rst = 1'b1;
  logic              cmd_req = 1'b0;
  logic              cmd_rdy;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              cmd_dir  = 1'b0;
  logic [CNT_W-1:0]  cmd_cnt  = '0;
  logic              ld_sft_reg;
  logic [DATA_W-1:0] sft_reg_in;
  logic [1:0]        LR_sft_en;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] sft_reg_out;

  int checks = 0;
  int errors = 0;
  bit inv_on = 1'b0;

  always #5 sys_clk = ~sys_clk;

  sft_reg_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .cmd_req    (cmd_req),
    .cmd_rdy    (cmd_rdy),
    .cmd_data   (cmd_data),
    .cmd_dir    (cmd_dir),
    .cmd_cnt    (cmd_cnt),
    .ld_sft_reg (ld_sft_reg),
    .sft_reg_in (sft_reg_in),
    .LR_sft_en  (LR_sft_en),
    .busy       (busy),
    .done       (done)
  );

  // Register reset is separate: a controller reset must not clear it.
  sft_register #(.DATA_W(DATA_W)) u_reg (
    .sys_clk     (sys_clk),
    .rst         (reg_rst),
    .ld_sft_reg  (ld_sft_reg),
    .sft_reg_in  (sft_reg_in),
    .LR_sft_en   (LR_sft_en),
    .sft_reg_out (sft_reg_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Final register value: n single-bit shifts with zero fill, as arithmetic.
  function automatic logic [DATA_W-1:0] model_result(input logic [DATA_W-1:0] d,
                                                     input bit dir, input int n);
    int v;
    v = int'(d);
    for (int i = 0; i < n; i++) begin
      v = dir ? (v / 2) : ((v * 2) % (1 << DATA_W));
    end
    return v[DATA_W-1:0];
  endfunction

  // Invariants on every cycle once out of the initial reset.
  always @(negedge sys_clk) begin
    if (inv_on) begin
      check("inv_ld_and_shift", {31'b0, ld_sft_reg & LR_sft_en[1]}, 32'd0);
      check("inv_lr_01", {31'b0, LR_sft_en == 2'b01}, 32'd0);
    end
  end

  task automatic check_idle_reset(input string tag);
    check({tag, "_ld"},   {31'b0, ld_sft_reg}, 32'd0);
    check({tag, "_lr"},   {30'b0, LR_sft_en},  32'd0);
    check({tag, "_in"},   {23'b0, sft_reg_in}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy},       32'd0);
    check({tag, "_done"}, {31'b0, done},       32'd0);
    check({tag, "_rdy"},  {31'b0, cmd_rdy},    32'd1);
  endtask

  // Called at a negedge; returns at a negedge with cmd_rdy high or bound hit.
  task automatic wait_rdy();
    int g = 0;
    while (cmd_rdy !== 1'b1 && g < 50) begin
      @(negedge sys_clk);
      g++;
    end
    check("rdy_wait", {31'b0, cmd_rdy}, 32'd1);
  endtask

  // Issue one command and check every cycle of its timeline. With inject set,
  // a second command is held on cmd_req throughout the shift phase.
  task automatic run_cmd(input logic [DATA_W-1:0] d, input bit dir,
                         input logic [CNT_W-1:0] cnt, input bit inject);
    int n;
    logic [1:0] code;
    logic [DATA_W-1:0] exp_res;
    n       = (int'(cnt) > DATA_W) ? DATA_W : int'(cnt);
    code    = dir ? 2'b11 : 2'b10;
    exp_res = model_result(d, dir, n);
    wait_rdy();
    cmd_data = d;
    cmd_dir  = dir;
    cmd_cnt  = cnt;
    cmd_req  = 1'b1;
    @(posedge sys_clk);
    #1;
    cmd_req  = 1'b0;
    cmd_data = DATA_W'($urandom);
    cmd_dir  = 1'($urandom);
    cmd_cnt  = CNT_W'($urandom);
    for (int k = 1; k <= n + 3; k++) begin
      @(negedge sys_clk);
      check("ld",     {31'b0, ld_sft_reg}, {31'b0, k == 1});
      check("lr",     {30'b0, LR_sft_en},  (k >= 2 && k <= n + 1) ? {30'b0, code} : 32'd0);
      check("done",   {31'b0, done},       {31'b0, k == n + 2});
      check("busy",   {31'b0, busy},       {31'b0, k <= n + 2});
      check("rdy",    {31'b0, cmd_rdy},    {31'b0, k > n + 2});
      check("sft_in", {23'b0, sft_reg_in}, {23'b0, d});
      if (k == n + 2) check("result", {23'b0, sft_reg_out}, {23'b0, exp_res});
      if (inject && k == 2) begin
        cmd_req  = 1'b1;
        cmd_data = 9'h001;
        cmd_dir  = 1'b1;
        cmd_cnt  = 4'd1;
      end
      if (k == n + 2) cmd_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic [CNT_W-1:0]  c;
    bit                dr;

    // 1. Reset with a request held: nothing may be accepted.
    cmd_req  = 1'b1;
    cmd_data = 9'h1AB;
    cmd_cnt  = 4'd3;
    @(posedge sys_clk);
    inv_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check_idle_reset("rst");
    end
    rst     = 1'b0;
    reg_rst = 1'b0;
    cmd_req = 1'b0;
    @(negedge sys_clk);
    check_idle_reset("post_rst");

    // 2..4. Directed commands.
    run_cmd(9'h0B5, 1'b0, 4'd3,  1'b0);
    run_cmd(9'h1FF, 1'b1, 4'd0,  1'b0);
    run_cmd(9'h155, 1'b1, 4'd15, 1'b0);
    check("sat_zero", {23'b0, sft_reg_out}, 32'd0);

    // 5. Request during SHIFT is ignored, then a fresh one is accepted.
    run_cmd(9'h0F3, 1'b0, 4'd4, 1'b1);
    run_cmd(9'h001, 1'b1, 4'd1, 1'b0);

    // 6. Reset in the second SHIFT cycle of a cnt=5 command.
    wait_rdy();
    cmd_data = 9'h12C;
    cmd_dir  = 1'b0;
    cmd_cnt  = 4'd5;
    cmd_req  = 1'b1;
    @(posedge sys_clk);
    #1;
    cmd_req = 1'b0;
    for (int k = 1; k <= 3; k++) @(negedge sys_clk);
    check("pre_rst_lr", {30'b0, LR_sft_en}, 32'd2);
    rst = 1'b1;
    @(negedge sys_clk);
    check_idle_reset("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      check("no_done_after_rst", {31'b0, done}, 32'd0);
    end
    run_cmd(9'h0AA, 1'b1, 4'd1, 1'b0);

    // Randomized commands.
    for (int t = 0; t < 24; t++) begin
      d  = DATA_W'($urandom);
      dr = 1'($urandom);
      c  = CNT_W'($urandom_range(0, 15));
      run_cmd(d, dr, c, (c >= 2) ? 1'($urandom) : 1'b0);
    end

    @(negedge sys_clk);
    inv_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sft_reg_ctrl
`default_nettype wire
